// File: rtl/doodle_pkg.sv
// doodle_pkg: shared states, fraction base and screen bounds for the doodle physics slice
package doodle_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2, DEAD = 2'd3} state_t;
  localparam int FRAC = 16;
  localparam int Y_TOP = 34;
  localparam int Y_BOT = 514;
  localparam int X_LEFT = 150;
  localparam int X_RIGHT = 800;
  localparam int STEP_PX = 2;
endpackage

// File: rtl/doodle_if.sv
// doodle_if: physics-to-controller bus; score port present only with DOODLE_SCORE_EN
interface doodle_if;
  logic       tick;
  logic       start;
  logic       on_platform;
  logic [9:0] ypos;
  logic       up;
  logic       down;
  logic [9:0] v_counter;
  logic       game_over;
  logic [1:0] state_o;
`ifdef DOODLE_SCORE_EN
  logic [15:0] score;
`endif
  modport master (
    input tick, start, on_platform, ypos,
    output up, down, v_counter, game_over, state_o
`ifdef DOODLE_SCORE_EN
    , output score
`endif
  );
  modport slave (
    output tick, start, on_platform, ypos,
    input up, down, v_counter, game_over, state_o
`ifdef DOODLE_SCORE_EN
    , input score
`endif
  );
endinterface

// File: rtl/doodle_step_gen.sv
// doodle_step_gen: fractional accumulator turning a 1/16 velocity into whole move events
module doodle_step_gen
  import doodle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clear,
  input  logic [4:0] vel,
  output logic       move
);
  logic [3:0] acc;
  logic [4:0] sum;
  assign sum = {1'b0, acc} + vel;
  assign move = sum >= 5'(FRAC);
  // The fraction wraps at 16, so the low nibble of the sum is the new remainder either way
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= clear ? '0 : tick ? sum[3:0] : acc;
endmodule

// File: rtl/doodle_physics.sv
// doodle_physics: jump/gravity FSM producing up/down strobes and world scroll; DOODLE_SCORE_EN adds score
module doodle_physics
  import doodle_pkg::*;
#(
  parameter int JUMP_VEL     = 16,
  parameter int MAX_FALL_VEL = 16,
  parameter int GRAV_PERIOD  = 4,
  parameter int SCROLL_Y     = 200,
  parameter int FLOOR_Y      = doodle_pkg::Y_BOT,
  parameter int STEP_PX      = doodle_pkg::STEP_PX
) (
  input logic      clk,
  input logic      rst,
  doodle_if.master bus
);
  state_t      state, state_n;
  logic [4:0]  vel, vel_n;
  logic [7:0]  gcnt, gcnt_n;
  logic        up, up_n, down, down_n;
  logic [9:0]  v_counter, vc_n;
  logic        clr, step_tick, move, g_wrap;
`ifdef DOODLE_SCORE_EN
  logic [15:0] score, score_n;
  assign bus.score = score;
`endif
  assign g_wrap = gcnt == 8'(GRAV_PERIOD - 1);
  assign bus.up = up;
  assign bus.down = down;
  assign bus.v_counter = v_counter;
  assign bus.game_over = state == DEAD;
  assign bus.state_o = state;
  doodle_step_gen u_step (
    .clk(clk), .rst(rst), .tick(step_tick), .clear(clr), .vel(vel), .move(move)
  );
  // Next-state, velocity/gravity, scroll and strobe decisions for the current tick
  always_comb begin
    state_n = state;
    vel_n = vel;
    gcnt_n = gcnt;
    up_n = 1'b0;
    down_n = 1'b0;
    vc_n = v_counter;
    clr = 1'b0;
    step_tick = 1'b0;
`ifdef DOODLE_SCORE_EN
    score_n = score;
`endif
    case (state)
      IDLE: if (bus.start) begin
        state_n = RISE;
        vel_n = 5'(JUMP_VEL);
        gcnt_n = '0;
        clr = 1'b1;
      end
      RISE: if (bus.tick) begin
        step_tick = 1'b1;
        up_n = move && bus.ypos > 10'(SCROLL_Y);
        if (move && bus.ypos <= 10'(SCROLL_Y)) begin
          vc_n = v_counter + 10'(STEP_PX);
`ifdef DOODLE_SCORE_EN
          score_n = score > 16'hFFFF - 16'(STEP_PX) ? 16'hFFFF : score + 16'(STEP_PX);
`endif
        end
        gcnt_n = g_wrap ? '0 : gcnt + 8'd1;
        vel_n = g_wrap ? vel - 5'd1 : vel;
        if (vel_n == 5'd0) begin
          state_n = FALL;
          gcnt_n = '0;
          clr = 1'b1;
        end
      end
      FALL: if (bus.tick) begin
        if (bus.on_platform) begin
          state_n = RISE;
          vel_n = 5'(JUMP_VEL);
          gcnt_n = '0;
          clr = 1'b1;
        end else if (bus.ypos >= 10'(FLOOR_Y)) begin
          state_n = DEAD;
        end else begin
          step_tick = 1'b1;
          down_n = move;
          gcnt_n = g_wrap ? '0 : gcnt + 8'd1;
          vel_n = g_wrap && vel < 5'(MAX_FALL_VEL) ? vel + 5'd1 : vel;
        end
      end
      default: ;
    endcase
  end
  // State and datapath registers; reset clears any in-flight strobe at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vel <= '0;
      gcnt <= '0;
      up <= 1'b0;
      down <= 1'b0;
      v_counter <= '0;
`ifdef DOODLE_SCORE_EN
      score <= '0;
`endif
    end else begin
      state <= state_n;
      vel <= vel_n;
      gcnt <= gcnt_n;
      up <= up_n;
      down <= down_n;
      v_counter <= vc_n;
`ifdef DOODLE_SCORE_EN
      score <= score_n;
`endif
    end
endmodule

// File: tb/tb_doodle_physics.sv
// tb_doodle_physics: scoreboard bench for doodle_physics (strobe queue plus state snapshots)
module tb_doodle_physics;
  logic clk = 1'b0;
  logic rst = 1'b1;
  doodle_if b();
  doodle_physics dut (.clk(clk), .rst(rst), .bus(b.master));
  always #5 clk = ~clk;
  typedef struct {bit is_up; int t;} pulse_t;
  typedef struct {string name; int st; int vc; bit go; int sc;} snap_t;
  pulse_t pq[$];
  snap_t  sq[$];
  int vecs = 0;
  int fails = 0;
  int tk = 0;
  event snap_ev;
  // Every strobe the DUT emits is matched against the next expected pulse
  always @(negedge clk) if (b.up || b.down) begin
    pulse_t e;
    vecs++;
    if (pq.size() == 0) begin
      fails++;
      $display("FAIL stray_pulse: got up=%0b down=%0b at tick %0d, required no pulse", b.up, b.down, tk);
    end else begin
      e = pq.pop_front();
      if (b.up !== e.is_up || b.down !== !e.is_up || (e.t >= 0 && tk != e.t)) begin
        fails++;
        $display("FAIL pulse: got up=%0b down=%0b at tick %0d, required %s at tick %0d", b.up, b.down, tk, e.is_up ? "up" : "down", e.t);
      end
    end
  end
  // Snapshot checks of the observable state, requested by the stimulus
  always @(snap_ev) begin
    snap_t s;
    int sc;
    vecs++;
    if (sq.size() == 0) begin
      fails++;
      $display("FAIL snapshot_queue: got empty queue, required an entry");
    end else begin
      s = sq.pop_front();
      sc = s.sc;
`ifdef DOODLE_SCORE_EN
      sc = int'(b.score);
`endif
      if (b.state_o !== 2'(s.st) || b.v_counter !== 10'(s.vc) || b.game_over !== s.go || sc != s.sc ||
          (s.st == 0 && (b.up || b.down))) begin
        fails++;
        $display("FAIL %s: got state=%0d vc=%0d go=%0b score=%0d up=%0b down=%0b, required state=%0d vc=%0d go=%0b score=%0d",
                 s.name, b.state_o, b.v_counter, b.game_over, sc, b.up, b.down, s.st, s.vc, s.go, s.sc);
      end
    end
  end
  task automatic snap(input string name, input int st, input int vc, input bit go, input int sc);
    sq.push_back('{name, st, vc, go, sc});
    -> snap_ev;
    #1;
  endtask
  task automatic exp_pulse(input bit is_up, input int t);
    pq.push_back('{is_up, t});
  endtask
  task automatic drained(input string name);
    vecs++;
    if (pq.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d expected pulses never seen, required 0", name, pq.size());
    end
    pq.delete();
  endtask
  task automatic do_tick;
    @(negedge clk);
    b.tick = 1'b1;
    tk++;
    @(negedge clk);
    b.tick = 1'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask
  task automatic pulse_start;
    @(negedge clk);
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
  endtask
  task automatic bounce;
    b.on_platform = 1'b1;
    do_tick();
    b.on_platform = 1'b0;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    b.tick = 1'b0;
    b.start = 1'b0;
    b.on_platform = 1'b0;
    b.ypos = 10'd300;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap("reset_state", 0, 0, 0, 0);
    tk = 0;
    exp_pulse(1, 1);
    repeat (32) exp_pulse(1, -1);
    exp_pulse(1, 64);
    pulse_start();
    ticks(64);
    snap("rise_to_fall", 2, 0, 0, 0);
    drained("rise_up_count");
    tk = 0;
    exp_pulse(0, 14);
    repeat (28) exp_pulse(0, -1);
    exp_pulse(0, 64);
    for (int i = 65; i <= 68; i++) exp_pulse(0, i);
    ticks(68);
    snap("fall_sat", 2, 0, 0, 0);
    drained("fall_down_count");
    b.ypos = 10'd514;
    bounce();
    snap("platform_beats_floor", 1, 0, 0, 0);
    drained("platform_no_down");
    do_reset();
    snap("reset_after_rise", 0, 0, 0, 0);
    b.ypos = 10'd150;
    pulse_start();
    ticks(64);
    snap("scroll_jump", 2, 68, 0, 68);
    b.ypos = 10'd514;
    do_tick();
    snap("floor_death", 3, 68, 1, 68);
    b.start = 1'b1;
    ticks(3);
    b.start = 1'b0;
    snap("dead_sticky", 3, 68, 1, 68);
    do_reset();
    snap("reset_from_dead", 0, 0, 0, 0);
    b.ypos = 10'd150;
    pulse_start();
    for (int j = 0; j < 15; j++) begin
      ticks(64);
      bounce();
    end
    snap("scroll_1020", 1, 1020, 0, 1020);
    do_tick();
    snap("scroll_1022", 1, 1022, 0, 1022);
    do_tick();
    snap("scroll_wrap", 1, 0, 0, 1024);
    drained("scroll_no_up");
    b.ypos = 10'd300;
    @(negedge clk);
    b.tick = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (b.up !== 1'b1) begin
      fails++;
      $display("FAIL inflight_up: got up=%0b, required 1", b.up);
    end
    rst = 1'b1;
    #1;
    snap("async_reset", 0, 0, 0, 0);
    b.tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ticks(2);
    snap("idle_after_async", 0, 0, 0, 0);
    drained("no_pulse_after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
